// File: rtl/icache_fetch.sv
// icache_fetch: direct-mapped read-only instruction cache with 4-word blocks and a stalling refill FSM.
// Define ICACHE_STATS_EN to build saturating hit/miss counters; otherwise HIT_COUNT/MISS_COUNT read 0.
module icache_fetch #(
  parameter int INDEX_BITS = 3,
  parameter int TAG_BITS = 3
) (
  input  logic                           CLK,
  input  logic                           RESET,
  input  logic                           READ,
  input  logic [31:0]                    PC,
  output logic [31:0]                    INSTRUCTION,
  output logic                           BUSYWAIT,
  output logic                           MEM_READ,
  output logic [TAG_BITS+INDEX_BITS-1:0] MEM_ADDRESS,
  input  logic [127:0]                   MEM_READDATA,
  input  logic                           MEM_BUSYWAIT,
  output logic [15:0]                    HIT_COUNT,
  output logic [15:0]                    MISS_COUNT
);
  localparam int AW = TAG_BITS + INDEX_BITS;
  localparam int LINES = 1 << INDEX_BITS;
  typedef enum logic [1:0] {S_IDLE, S_MEM_READ, S_UPDATE} state_t;
  state_t state, state_nx;
  logic [LINES-1:0] valid;
  logic [TAG_BITS-1:0] tags [LINES];
  logic [127:0] data [LINES];
  logic [127:0] block;
  logic [AW-1:0] miss_addr;
  logic [1:0] offset;
  logic [INDEX_BITS-1:0] index;
  logic [TAG_BITS-1:0] tag;
  logic hit, miss, pc_unused;
  assign offset = PC[3:2];
  assign index = PC[INDEX_BITS+3:4];
  assign tag = PC[AW+3:INDEX_BITS+4];
  assign pc_unused = ^{PC[31:AW+4], PC[1:0]};
  assign hit = READ & valid[index] & (tags[index] == tag);
  assign miss = (state == S_IDLE) & READ & !hit;
  assign INSTRUCTION = (READ & !RESET) ? data[index][{offset, 5'b0} +: 32] : 32'h0;
  assign BUSYWAIT = !RESET & ((state != S_IDLE) | miss);
  assign MEM_READ = state == S_MEM_READ;
  assign MEM_ADDRESS = miss_addr;
  always_comb begin
    state_nx = state;
    if (miss) state_nx = S_MEM_READ;
    else if (state == S_MEM_READ && !MEM_BUSYWAIT) state_nx = S_UPDATE;
    else if (state == S_UPDATE) state_nx = S_IDLE;
  end
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state <= S_IDLE;
      valid <= '0;
      miss_addr <= '0;
    end else begin
      state <= state_nx;
      if (miss) miss_addr <= {tag, index};
      if (state == S_UPDATE) valid[miss_addr[INDEX_BITS-1:0]] <= 1'b1;
    end
  end
  // Payload storage carries no reset; only the valid bits gate its use.
  always_ff @(posedge CLK) begin
    if (state == S_MEM_READ && !MEM_BUSYWAIT) block <= MEM_READDATA;
    if (state == S_UPDATE) begin
      data[miss_addr[INDEX_BITS-1:0]] <= block;
      tags[miss_addr[INDEX_BITS-1:0]] <= miss_addr[AW-1:INDEX_BITS];
    end
  end
`ifdef ICACHE_STATS_EN
  logic [15:0] hit_count, miss_count;
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      hit_count <= '0;
      miss_count <= '0;
    end else begin
      if (state == S_IDLE && hit && hit_count != 16'hFFFF) hit_count <= hit_count + 16'd1;
      if (miss && miss_count != 16'hFFFF) miss_count <= miss_count + 16'd1;
    end
  end
  assign HIT_COUNT = hit_count;
  assign MISS_COUNT = miss_count;
`else
  assign HIT_COUNT = 16'h0;
  assign MISS_COUNT = 16'h0;
`endif
endmodule
